// File: rtl/load_scoreboard_pkg.sv
// load_scoreboard_pkg: shared types and widths for the load scoreboard.
//   LU_DEPTH         - default number of loads in flight
//   DS_TO_SB_BUS_WD  - width of {ds_rf_raddr1, ds_rf_raddr2, ds_valid}
//   ES_TO_SB_BUS_WD  - width of {es_ld_issue, es_ld_dest}
//   ld_entry_t       - one FIFO slot: destination register plus stale flag
package load_scoreboard_pkg;

    localparam int unsigned LU_DEPTH        = 4;
    localparam int unsigned DS_TO_SB_BUS_WD = 11;
    localparam int unsigned ES_TO_SB_BUS_WD = 6;

    typedef struct packed {
        logic [4:0] dest;
        logic       stale;
    } ld_entry_t;

endpackage

// File: rtl/load_scoreboard_fifo.sv
// ld_dest_fifo: ordered storage of outstanding load destinations.
//   clk, resetn   - clock, asynchronous active-low reset
//   push_i        - enqueue push_dest_i (caller guarantees not full, no flush)
//   push_dest_i   - destination register of the issuing load
//   pop_i         - dequeue the head (caller guarantees not empty)
//   flush_i       - mark every resident entry stale
//   head_o        - head entry, all-zero when empty
//   full_o        - DEPTH entries occupied
//   empty_o       - no entries occupied
module ld_dest_fifo
    import load_scoreboard_pkg::*;
#(
    parameter int unsigned DEPTH = LU_DEPTH,
    parameter int unsigned PTR_W = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       push_i,
    input  logic [4:0] push_dest_i,
    input  logic       pop_i,
    input  logic       flush_i,
    output ld_entry_t  head_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    ld_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    always_comb begin
        rd_ptr_d = pop_i  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d  = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + 1'b1;
        end else if (!push_i && pop_i) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Stale is set on every slot, not just occupied ones: free slots
            // are always rewritten with stale=0 before they become visible.
            if (flush_i) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    mem_q[i].stale <= 1'b1;
                end
            end
            if (push_i) begin
                mem_q[wr_ptr_q] <= '{dest: push_dest_i, stale: 1'b0};
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/load_scoreboard.sv
// load_scoreboard: holds decode while a source register awaits load data.
//   clk, resetn                  - clock, asynchronous active-low reset
//   ds_valid, ds_rf_raddr1/2     - decode instruction and its source registers
//   ds_stall                     - hold decode this cycle
//   es_ld_issue, es_ld_dest      - load leaving EX for memory
//   es_ld_ready                  - room for another outstanding load
//   ld_ret                       - oldest load's data returns this cycle
//   ld_ret_dest, ld_ret_stale    - head entry's destination / flushed flag
//   flush                        - pipeline flush
//   sb_empty                     - nothing outstanding
//   sb_err                       - sticky: return seen with nothing outstanding
module load_scoreboard
    import load_scoreboard_pkg::*;
#(
    parameter int unsigned DEPTH = LU_DEPTH,
    parameter int unsigned PTR_W = 2,
    parameter int unsigned CNT_W = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ds_valid,
    input  logic [4:0] ds_rf_raddr1,
    input  logic [4:0] ds_rf_raddr2,
    output logic       ds_stall,
    input  logic       es_ld_issue,
    input  logic [4:0] es_ld_dest,
    output logic       es_ld_ready,
    input  logic       ld_ret,
    output logic [4:0] ld_ret_dest,
    output logic       ld_ret_stale,
    input  logic       flush,
    output logic       sb_empty,
    output logic       sb_err
);

    logic [DS_TO_SB_BUS_WD-1:0] ds_bus;
    logic [ES_TO_SB_BUS_WD-1:0] es_bus;
    logic       d_valid, e_issue;
    logic [4:0] d_r1, d_r2, e_dest;

    assign ds_bus  = {ds_rf_raddr1, ds_rf_raddr2, ds_valid};
    assign es_bus  = {es_ld_issue, es_ld_dest};
    assign d_r1    = ds_bus[10:6];
    assign d_r2    = ds_bus[5:1];
    assign d_valid = ds_bus[0];
    assign e_issue = es_bus[5];
    assign e_dest  = es_bus[4:0];

    ld_entry_t  head;
    logic       full, empty, push, pop;
    logic [CNT_W-1:0] pend_q [32];
    logic [CNT_W-1:0] pend_d [32];
    logic       sb_err_q;
    logic       hit1, hit2;

    assign push = e_issue && !full && !flush;
    assign pop  = ld_ret && !empty;

    ld_dest_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .push_i      (push),
        .push_dest_i (e_dest),
        .pop_i       (pop),
        .flush_i     (flush),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty)
    );

    // Increment then decrement in sequence so a push and pop on the same
    // register cancel. Stale heads were already cleared by the flush.
    always_comb begin
        pend_d = pend_q;
        if (flush) begin
            for (int unsigned i = 0; i < 32; i++) begin
                pend_d[i] = '0;
            end
        end else begin
            if (push && e_dest != 5'd0) begin
                pend_d[e_dest] = pend_d[e_dest] + CNT_W'(1);
            end
            if (pop && !head.stale && head.dest != 5'd0) begin
                pend_d[head.dest] = pend_d[head.dest] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < 32; i++) begin
                pend_q[i] <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            sb_err_q <= sb_err_q | (ld_ret & empty);
        end
    end

    // The EX-stage term covers the cycle before the counter is visible.
    assign hit1 = (d_r1 != 5'd0) &&
                  ((pend_q[d_r1] != '0) || (e_issue && e_dest == d_r1));
    assign hit2 = (d_r2 != 5'd0) &&
                  ((pend_q[d_r2] != '0) || (e_issue && e_dest == d_r2));

    assign ds_stall     = d_valid && (hit1 || hit2);
    assign es_ld_ready  = !full;
    assign ld_ret_dest  = head.dest;
    assign ld_ret_stale = head.stale;
    assign sb_empty     = empty;
    assign sb_err       = sb_err_q;

endmodule

// File: tb/tb_load_scoreboard.sv
module tb_load_scoreboard;

    logic       clk = 1'b0;
    logic       resetn;
    logic       ds_valid;
    logic [4:0] ds_rf_raddr1, ds_rf_raddr2;
    logic       ds_stall;
    logic       es_ld_issue;
    logic [4:0] es_ld_dest;
    logic       es_ld_ready;
    logic       ld_ret;
    logic [4:0] ld_ret_dest;
    logic       ld_ret_stale;
    logic       flush;
    logic       sb_empty;
    logic       sb_err;

    int checks   = 0;
    int failures = 0;

    // Scoreboard of expected returns: {dest, stale}
    logic [5:0] exp_q [$];
    logic [5:0] e;

    always #5 clk = ~clk;

    load_scoreboard #(
        .DEPTH (4),
        .PTR_W (2),
        .CNT_W (3)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .ds_valid     (ds_valid),
        .ds_rf_raddr1 (ds_rf_raddr1),
        .ds_rf_raddr2 (ds_rf_raddr2),
        .ds_stall     (ds_stall),
        .es_ld_issue  (es_ld_issue),
        .es_ld_dest   (es_ld_dest),
        .es_ld_ready  (es_ld_ready),
        .ld_ret       (ld_ret),
        .ld_ret_dest  (ld_ret_dest),
        .ld_ret_stale (ld_ret_stale),
        .flush        (flush),
        .sb_empty     (sb_empty),
        .sb_err       (sb_err)
    );

    // Apply one cycle of inputs mid-period; outputs settle 1ns later.
    task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic iss, input logic [4:0] d,
                         input logic ret, input logic fl);
        @(negedge clk);
        ds_valid     = v;
        ds_rf_raddr1 = r1;
        ds_rf_raddr2 = r2;
        es_ld_issue  = iss;
        es_ld_dest   = d;
        ld_ret       = ret;
        flush        = fl;
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        ds_valid = 1'b1; ds_rf_raddr1 = 5'd5; ds_rf_raddr2 = 5'd0;
        es_ld_issue = 1'b0; es_ld_dest = 5'd0; ld_ret = 1'b0; flush = 1'b0;
        #22;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        checks++; if (ds_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", ds_stall); end
        checks++; if (es_ld_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", es_ld_ready); end
        checks++; if (sb_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", sb_empty); end
        checks++; if (ld_ret_dest !== 5'd0) begin failures++; $display("FAIL reset_dest got=%0d exp=0", ld_ret_dest); end
        checks++; if (ld_ret_stale !== 1'b0) begin failures++; $display("FAIL reset_stale got=%b exp=0", ld_ret_stale); end
        checks++; if (sb_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", sb_err); end
        drive(1, 5, 0, 0, 0, 0, 0);
        checks++; if (ds_stall !== 1'b0) begin failures++; $display("FAIL idle_stall got=%b exp=0", ds_stall); end
    endtask

    task automatic test_bypass();
        drive(1, 0, 5, 1, 5, 0, 0);
        checks++; if (ds_stall !== 1'b1) begin failures++; $display("FAIL bypass_issue_stall got=%b exp=1", ds_stall); end
        exp_q.push_back({5'd5, 1'b0});
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 5, 0, 0, 0, 0);
            checks++; if (ds_stall !== 1'b1) begin failures++; $display("FAIL bypass_hold_stall cyc=%0d got=%b exp=1", i, ds_stall); end
        end
        drive(1, 0, 5, 0, 0, 1, 0);
        checks++; if (ds_stall !== 1'b1) begin failures++; $display("FAIL bypass_ret_stall got=%b exp=1", ds_stall); end
        if (exp_q.size() == 0) begin
            checks++; failures++; $display("FAIL bypass_ret scoreboard empty got=%0d exp=none", ld_ret_dest);
        end else begin
            e = exp_q.pop_front();
            checks++; if (ld_ret_dest !== e[5:1]) begin failures++; $display("FAIL bypass_ret_dest got=%0d exp=%0d", ld_ret_dest, e[5:1]); end
            checks++; if (ld_ret_stale !== e[0]) begin failures++; $display("FAIL bypass_ret_stale got=%b exp=%b", ld_ret_stale, e[0]); end
        end
        drive(1, 0, 5, 0, 0, 0, 0);
        checks++; if (ds_stall !== 1'b0) begin failures++; $display("FAIL bypass_after_stall got=%b exp=0", ds_stall); end
        checks++; if (sb_empty !== 1'b1) begin failures++; $display("FAIL bypass_after_empty got=%b exp=1", sb_empty); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] dl [4];
        dl[0] = 5'd3; dl[1] = 5'd3; dl[2] = 5'd7; dl[3] = 5'd9;
        for (int i = 0; i < 4; i++) begin
            drive(1, 3, 0, 1, dl[i], 0, 0);
            checks++; if (es_ld_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready idx=%0d got=%b exp=1", i, es_ld_ready); end
            exp_q.push_back({dl[i], 1'b0});
        end
        // Full: fifth issue refused even though a return pops this cycle.
        drive(1, 3, 0, 1, 11, 1, 0);
        checks++; if (es_ld_ready !== 1'b0) begin failures++; $display("FAIL b2b_full_ready got=%b exp=0", es_ld_ready); end
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                drive(1, 3, 0, 0, 0, 0, 0);
                checks++; if (ds_stall !== 1'b1) begin failures++; $display("FAIL b2b_pend3_stall got=%b exp=1", ds_stall); end
                drive(1, 3, 0, 0, 0, 1, 0);
            end else if (k == 2) begin
                drive(1, 3, 0, 0, 0, 0, 0);
                checks++; if (ds_stall !== 1'b0) begin failures++; $display("FAIL b2b_pend3_clear got=%b exp=0", ds_stall); end
                drive(1, 7, 9, 0, 0, 1, 0);
                checks++; if (ds_stall !== 1'b1) begin failures++; $display("FAIL b2b_pend79_stall got=%b exp=1", ds_stall); end
            end else if (k == 3) begin
                drive(1, 7, 9, 0, 0, 1, 0);
                checks++; if (ds_stall !== 1'b1) begin failures++; $display("FAIL b2b_pend9_stall got=%b exp=1", ds_stall); end
            end
            if (exp_q.size() == 0) begin
                checks++; failures++; $display("FAIL b2b_ret scoreboard empty got=%0d exp=none", ld_ret_dest);
            end else begin
                e = exp_q.pop_front();
                checks++; if (ld_ret_dest !== e[5:1]) begin failures++; $display("FAIL b2b_ret_dest k=%0d got=%0d exp=%0d", k, ld_ret_dest, e[5:1]); end
                checks++; if (ld_ret_stale !== e[0]) begin failures++; $display("FAIL b2b_ret_stale k=%0d got=%b exp=%b", k, ld_ret_stale, e[0]); end
            end
        end
        drive(1, 7, 9, 0, 0, 0, 0);
        checks++; if (ds_stall !== 1'b0) begin failures++; $display("FAIL b2b_end_stall got=%b exp=0", ds_stall); end
        checks++; if (sb_empty !== 1'b1) begin failures++; $display("FAIL b2b_end_empty got=%b exp=1", sb_empty); end
        checks++; if (es_ld_ready !== 1'b1) begin failures++; $display("FAIL b2b_end_ready got=%b exp=1", es_ld_ready); end
    endtask

    task automatic test_r0();
        drive(1, 0, 0, 1, 0, 0, 0);
        checks++; if (ds_stall !== 1'b0) begin failures++; $display("FAIL r0_issue_stall got=%b exp=0", ds_stall); end
        exp_q.push_back({5'd0, 1'b0});
        drive(1, 0, 0, 0, 0, 0, 0);
        checks++; if (ds_stall !== 1'b0) begin failures++; $display("FAIL r0_hold_stall got=%b exp=0", ds_stall); end
        checks++; if (sb_empty !== 1'b0) begin failures++; $display("FAIL r0_enqueued got=%b exp=0", sb_empty); end
        drive(1, 0, 0, 0, 0, 1, 0);
        if (exp_q.size() == 0) begin
            checks++; failures++; $display("FAIL r0_ret scoreboard empty got=%0d exp=none", ld_ret_dest);
        end else begin
            e = exp_q.pop_front();
            checks++; if (ld_ret_dest !== e[5:1]) begin failures++; $display("FAIL r0_ret_dest got=%0d exp=%0d", ld_ret_dest, e[5:1]); end
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        checks++; if (sb_empty !== 1'b1) begin failures++; $display("FAIL r0_end_empty got=%b exp=1", sb_empty); end
    endtask

    task automatic test_flush();
        drive(1, 8, 0, 1, 8, 0, 0);
        checks++; if (ds_stall !== 1'b1) begin failures++; $display("FAIL flush_issue8_stall got=%b exp=1", ds_stall); end
        exp_q.push_back({5'd8, 1'b0});
        drive(1, 8, 12, 1, 12, 0, 0);
        exp_q.push_back({5'd12, 1'b0});
        drive(1, 8, 12, 1, 4, 0, 1);
        for (int i = 0; i < exp_q.size(); i++) begin
            exp_q[i][0] = 1'b1;
        end
        drive(1, 8, 12, 0, 0, 0, 0);
        checks++; if (ds_stall !== 1'b0) begin failures++; $display("FAIL flush_8_12_stall got=%b exp=0", ds_stall); end
        checks++; if (ld_ret_stale !== 1'b1) begin failures++; $display("FAIL flush_head_stale got=%b exp=1", ld_ret_stale); end
        drive(1, 4, 0, 0, 0, 0, 0);
        checks++; if (ds_stall !== 1'b0) begin failures++; $display("FAIL flush_4_stall got=%b exp=0", ds_stall); end
        for (int k = 0; k < 2; k++) begin
            drive(1, 8, 12, 0, 0, 1, 0);
            if (exp_q.size() == 0) begin
                checks++; failures++; $display("FAIL flush_ret scoreboard empty got=%0d exp=none", ld_ret_dest);
            end else begin
                e = exp_q.pop_front();
                checks++; if (ld_ret_dest !== e[5:1]) begin failures++; $display("FAIL flush_ret_dest k=%0d got=%0d exp=%0d", k, ld_ret_dest, e[5:1]); end
                checks++; if (ld_ret_stale !== e[0]) begin failures++; $display("FAIL flush_ret_stale k=%0d got=%b exp=%b", k, ld_ret_stale, e[0]); end
            end
        end
        drive(1, 8, 12, 0, 0, 0, 0);
        checks++; if (sb_empty !== 1'b1) begin failures++; $display("FAIL flush_end_empty got=%b exp=1", sb_empty); end
        checks++; if (ds_stall !== 1'b0) begin failures++; $display("FAIL flush_end_stall got=%b exp=0", ds_stall); end
    endtask

    task automatic test_err_and_reset();
        drive(0, 0, 0, 0, 0, 1, 0);
        checks++; if (sb_err !== 1'b0) begin failures++; $display("FAIL err_before got=%b exp=0", sb_err); end
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++; if (sb_err !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", sb_err); end
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++; if (sb_err !== 1'b1) begin failures++; $display("FAIL err_held got=%b exp=1", sb_err); end
        checks++; if (sb_empty !== 1'b1) begin failures++; $display("FAIL err_empty got=%b exp=1", sb_empty); end
        drive(1, 6, 0, 1, 6, 0, 0);
        drive(1, 6, 0, 1, 6, 0, 0);
        drive(1, 6, 0, 0, 0, 0, 0);
        checks++; if (ds_stall !== 1'b1) begin failures++; $display("FAIL pre_rst_stall got=%b exp=1", ds_stall); end
        checks++; if (sb_empty !== 1'b0) begin failures++; $display("FAIL pre_rst_empty got=%b exp=0", sb_empty); end
        #2 resetn = 1'b0;
        #1;
        checks++; if (sb_empty !== 1'b1) begin failures++; $display("FAIL arst_empty got=%b exp=1", sb_empty); end
        checks++; if (ds_stall !== 1'b0) begin failures++; $display("FAIL arst_stall got=%b exp=0", ds_stall); end
        checks++; if (sb_err !== 1'b0) begin failures++; $display("FAIL arst_err got=%b exp=0", sb_err); end
        checks++; if (ld_ret_dest !== 5'd0) begin failures++; $display("FAIL arst_dest got=%0d exp=0", ld_ret_dest); end
        @(negedge clk);
        resetn = 1'b1;
        exp_q.delete();
        drive(1, 6, 0, 0, 0, 0, 0);
        checks++; if (ds_stall !== 1'b0) begin failures++; $display("FAIL post_rst_stall got=%b exp=0", ds_stall); end
        checks++; if (es_ld_ready !== 1'b1) begin failures++; $display("FAIL post_rst_ready got=%b exp=1", es_ld_ready); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_back_to_back();
        test_r0();
        test_flush();
        test_err_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
